// File: rtl/ntt_bank_ram.sv
// ntt_bank_ram: multi-lane coefficient RAM with write-first forwarding and a zero-fill clear sequencer
module ntt_bank_ram #(
  parameter int WID = 16,
  parameter int AWID = 8,
  parameter int NPORT = 4,
  parameter logic [WID-1:0] CLR_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NPORT-1:0]      we_i,
  input  logic [NPORT*AWID-1:0] waddr_i,
  input  logic [NPORT*WID-1:0]  wdata_i,
  input  logic                  re_i,
  input  logic [NPORT*AWID-1:0] raddr_i,
  output logic [NPORT*WID-1:0]  rdata_o,
  output logic                  rvalid_o,
  input  logic                  clr_start_i,
  output logic                  busy_o,
  output logic                  clr_done_o
);
  localparam int DEP = 1 << AWID;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [AWID-1:0] STEP = AWID'(NPORT);
  localparam logic [AWID-1:0] LAST = AWID'(DEP - NPORT);
  logic [WID-1:0] mem_q [DEP];
  logic [1:0] state_q, state_d;
  logic [AWID-1:0] cnt_q, cnt_d;
  logic [NPORT*WID-1:0] rdata_q, rdata_d;
  logic rvalid_q, rvalid_d;
  logic busy;
  assign busy = state_q == S_CLEAR;
  assign busy_o = busy;
  assign clr_done_o = state_q == S_DONE;
  assign rdata_o = rdata_q;
  assign rvalid_o = rvalid_q;
  // Clear sequencer: counter steps NPORT words per cycle and wraps to 0 as it leaves CLEAR
  always_comb begin
    state_d = clr_start_i ? S_CLEAR : S_IDLE;
    cnt_d = '0;
    if (busy) begin
      state_d = cnt_q == LAST ? S_DONE : S_CLEAR;
      cnt_d = cnt_q + STEP;
    end
  end
  // Sequencer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // Read path: array lookup, overridden by the highest-index matching write lane (write-first)
  always_comb begin
    rdata_d = rdata_q;
    rvalid_d = re_i && !busy;
    for (int i = 0; i < NPORT; i++) begin
      if (rvalid_d) begin
        rdata_d[i*WID +: WID] = mem_q[raddr_i[i*AWID +: AWID]];
        for (int j = 0; j < NPORT; j++)
          if (we_i[j] && waddr_i[j*AWID +: AWID] == raddr_i[i*AWID +: AWID])
            rdata_d[i*WID +: WID] = wdata_i[j*WID +: WID];
      end
    end
  end
  // Read data registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end
  // Array: clear lanes own it while busy; otherwise later lanes override earlier ones on collision
  always_ff @(posedge clk_i) begin
    if (busy) begin
      for (int i = 0; i < NPORT; i++)
        mem_q[cnt_q + AWID'(i)] <= CLR_VAL;
    end else begin
      for (int i = 0; i < NPORT; i++)
        if (we_i[i]) mem_q[waddr_i[i*AWID +: AWID]] <= wdata_i[i*WID +: WID];
    end
  end
endmodule

// File: tb/tb_ntt_bank_ram.sv
// tb_ntt_bank_ram: table vectors, random traffic against an array model, clear and reset corner cases
module tb_ntt_bank_ram;
  localparam int W = 16;
  localparam int A = 8;
  localparam int N = 4;
  localparam int DEP = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] we = '0;
  logic [N*A-1:0] waddr = '0;
  logic [N*W-1:0] wdata = '0;
  logic re = 1'b0;
  logic [N*A-1:0] raddr = '0;
  logic [N*W-1:0] rdata;
  logic rvalid, clr_start = 1'b0, busy, clr_done;
  logic s_we = 1'b0, s_re = 1'b0, s_clr = 1'b0;
  logic [3:0] s_waddr = '0, s_raddr = '0;
  logic [W-1:0] s_wdata = '0, s_rdata;
  logic s_rvalid, s_busy, s_done;
  ntt_bank_ram #(.WID(W), .AWID(A), .NPORT(N), .CLR_VAL(16'h0000)) dut (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .re_i(re),
    .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid), .clr_start_i(clr_start),
    .busy_o(busy), .clr_done_o(clr_done)
  );
  ntt_bank_ram #(.WID(W), .AWID(4), .NPORT(1), .CLR_VAL(16'h0000)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .we_i(s_we), .waddr_i(s_waddr), .wdata_i(s_wdata), .re_i(s_re),
    .raddr_i(s_raddr), .rdata_o(s_rdata), .rvalid_o(s_rvalid), .clr_start_i(s_clr),
    .busy_o(s_busy), .clr_done_o(s_done)
  );
  typedef struct {
    logic [N-1:0] we;
    logic [N*A-1:0] waddr;
    logic [N*W-1:0] wdata;
    logic re;
    logic [N*A-1:0] raddr;
    logic [N*W-1:0] rd;
    logic rv;
  } vec_t;
  vec_t tv[9];
  int total = 0;
  int bad = 0;
  logic [W-1:0] model [DEP];
  logic [N*W-1:0] exp_rd = '0;
  logic exp_rv = 1'b0;
  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // Model: apply this cycle's writes first (lowest lane first, so the highest lane wins), then read.
  task automatic run;
    for (int i = 0; i < N; i++)
      if (we[i]) model[waddr[i*A +: A]] = wdata[i*W +: W];
    if (re)
      for (int i = 0; i < N; i++) exp_rd[i*W +: W] = model[raddr[i*A +: A]];
    exp_rv = re;
    step;
  endtask
  task automatic cmp(string tag);
    check({tag, " rvalid"}, 64'(rvalid), 64'(exp_rv));
    check({tag, " rdata"}, rdata, exp_rd);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(clr_done), 64'd0);
  endtask
  task automatic fill(input logic [W-1:0] v);
    re = 1'b0;
    we = '1;
    for (int k = 0; k < DEP / N; k++) begin
      for (int i = 0; i < N; i++) begin
        waddr[i*A +: A] = A'(k * N + i);
        wdata[i*W +: W] = v;
      end
      run;
    end
    we = '0;
  endtask
  task automatic read_all(string tag);
    re = 1'b1;
    for (int k = 0; k < DEP / N; k++) begin
      for (int i = 0; i < N; i++) raddr[i*A +: A] = A'(k * N + i);
      run;
      cmp($sformatf("%s k=%0d", tag, k));
    end
    re = 1'b0;
  endtask
  initial begin
    int bc;
    tv[0] = '{4'hF, {8'h13, 8'h12, 8'h11, 8'h10}, {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 1'b0, '0, '0, 1'b0};
    tv[1] = '{4'h0, '0, '0, 1'b1, {8'h13, 8'h12, 8'h11, 8'h10}, {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 1'b1};
    tv[2] = '{4'h1, {24'h0, 8'h20}, {48'h0, 16'h1234}, 1'b1, {8'h20, 8'h12, 8'h11, 8'h10}, {16'h1234, 16'hA002, 16'hA001, 16'hA000}, 1'b1};
    tv[3] = '{4'h0, '0, '0, 1'b1, {4{8'h20}}, {4{16'h1234}}, 1'b1};
    tv[4] = '{4'hF, {4{8'h30}}, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b1, {4{8'h30}}, {4{16'h0004}}, 1'b1};
    tv[5] = '{4'h0, '0, '0, 1'b1, {8'h30, 8'h20, 8'h13, 8'h10}, {16'h0004, 16'h1234, 16'hA003, 16'hA000}, 1'b1};
    tv[6] = '{4'h0, '0, '0, 1'b0, '0, {16'h0004, 16'h1234, 16'hA003, 16'hA000}, 1'b0};
    tv[7] = '{4'h6, {8'h0, 8'h40, 8'h40, 8'h0}, {16'h0, 16'h0006, 16'h0005, 16'h0}, 1'b1, {8'h30, 8'h40, 8'h40, 8'h40}, {16'h0004, 16'h0006, 16'h0006, 16'h0006}, 1'b1};
    tv[8] = '{4'h9, {8'h51, 8'h0, 8'h0, 8'h50}, {16'h8888, 16'h0, 16'h0, 16'h7777}, 1'b1, {8'h51, 8'h50, 8'h40, 8'h30}, {16'h8888, 16'h7777, 16'h0006, 16'h0004}, 1'b1};
    #1;
    check("reset rdata", rdata, 64'd0);
    check("reset rvalid", 64'(rvalid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(clr_done), 64'd0);
    step;
    step;
    rst_n = 1'b1;
    step;
    fill(16'h5A5A);
    for (int t = 0; t < 9; t++) begin
      we = tv[t].we; waddr = tv[t].waddr; wdata = tv[t].wdata; re = tv[t].re; raddr = tv[t].raddr;
      run;
      check($sformatf("vec%0d rdata", t), rdata, tv[t].rd);
      check($sformatf("vec%0d rvalid", t), 64'(rvalid), 64'(tv[t].rv));
    end
    for (int t = 0; t < 400; t++) begin
      we = N'($urandom);
      re = 1'($urandom);
      for (int i = 0; i < N; i++) begin
        waddr[i*A +: A] = 8'hC0 + A'($urandom_range(0, 15));
        raddr[i*A +: A] = 8'hC0 + A'($urandom_range(0, 15));
        wdata[i*W +: W] = W'($urandom);
      end
      run;
      cmp($sformatf("rand%0d", t));
    end
    we = '0;
    re = 1'b0;
    fill(16'hFFFF);
    clr_start = 1'b1;
    step;
    clr_start = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin
      check($sformatf("clr rvalid c%0d", bc), 64'(rvalid), 64'd0);
      check($sformatf("clr done c%0d", bc), 64'(clr_done), 64'd0);
      check($sformatf("clr hold c%0d", bc), rdata, exp_rd);
      we = '1;
      re = 1'b1;
      for (int i = 0; i < N; i++) begin
        waddr[i*A +: A] = A'($urandom);
        raddr[i*A +: A] = A'($urandom);
        wdata[i*W +: W] = W'($urandom);
      end
      step;
      bc++;
    end
    we = '0;
    re = 1'b0;
    check("clr busy cycles", 64'(bc), 64'd64);
    check("clr done pulse", 64'(clr_done), 64'd1);
    check("clr rvalid after", 64'(rvalid), 64'd0);
    step;
    check("clr done drop", 64'(clr_done), 64'd0);
    for (int a = 0; a < DEP; a++) model[a] = '0;
    exp_rv = 1'b0;
    read_all("clr read");
    fill(16'hFFFF);
    clr_start = 1'b1;
    step;
    clr_start = 1'b0;
    repeat (20) step;
    check("midclr busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midclr rst busy", 64'(busy), 64'd0);
    check("midclr rst rvalid", 64'(rvalid), 64'd0);
    check("midclr rst done", 64'(clr_done), 64'd0);
    check("midclr rst rdata", rdata, 64'd0);
    exp_rd = '0;
    exp_rv = 1'b0;
    for (int a = 0; a < 80; a++) model[a] = '0;
    step;
    rst_n = 1'b1;
    step;
    check("midclr no done", 64'(clr_done), 64'd0);
    read_all("midclr read");
    s_clr = 1'b1;
    step;
    s_clr = 1'b0;
    bc = 0;
    while (s_busy === 1'b1 && bc < 40) begin
      step;
      bc++;
    end
    check("n1 busy cycles", 64'(bc), 64'd16);
    check("n1 done pulse", 64'(s_done), 64'd1);
    step;
    s_re = 1'b1; s_raddr = 4'd5;
    step;
    check("n1 cleared rd", 64'(s_rdata), 64'd0);
    check("n1 cleared rv", 64'(s_rvalid), 64'd1);
    s_re = 1'b0; s_we = 1'b1; s_waddr = 4'd5; s_wdata = 16'hBEEF;
    step;
    check("n1 wr rv", 64'(s_rvalid), 64'd0);
    s_we = 1'b0; s_re = 1'b1;
    step;
    check("n1 raw", 64'(s_rdata), 64'hBEEF);
    s_we = 1'b1; s_waddr = 4'd9; s_wdata = 16'h1357; s_raddr = 4'd9;
    step;
    check("n1 fwd", 64'(s_rdata), 64'h1357);
    s_we = 1'b0;
    step;
    check("n1 fwd after", 64'(s_rdata), 64'h1357);
    check("n1 fwd rv", 64'(s_rvalid), 64'd1);
    s_re = 1'b0;
    step;
    check("n1 idle rv", 64'(s_rvalid), 64'd0);
    check("n1 hold", 64'(s_rdata), 64'h1357);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
